// File: rtl/ram_step_pkg.sv
// Shared types for the RAM stepping controller: FSM state encoding and scan mode constants.
package ram_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the divided clock; prev resets high so a level that is
// already high when reset is released does not count as an edge.
module tick_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic tick_o
);

  logic prev;

  // One-cycle delayed copy of the level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev <= 1'b1;
    end else begin
      prev <= level_i;
    end
  end

  assign tick_o = level_i & ~prev;

endmodule

// File: rtl/ram_step_ctrl.sv
// Steps through every RAM address, one access per slow_clk_i rising edge, reading or filling.
// Define RAM_STEP_LOOP_EN to make the scan wrap back to address 0 indefinitely instead of stopping.
module ram_step_ctrl
  import ram_step_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slow_clk_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] pattern_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic              mode;
  logic [DATA_W-1:0] pattern;
  logic              tick;

  tick_edge_det u_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (slow_clk_i),
    .tick_o  (tick)
  );

  // Scan sequencer; ram_addr_o doubles as the address counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      mode        <= MODE_READ;
      pattern     <= '0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ram_en_o <= 1'b0;
          ram_we_o <= 1'b0;
          done_o   <= 1'b0;
          if (start_i) begin
            state      <= ST_WAIT_TICK;
            ram_addr_o <= '0;
            busy_o     <= 1'b1;
            mode       <= mode_i;
            pattern    <= pattern_i;
          end
        end
        ST_WAIT_TICK: begin
          if (tick) begin
            state       <= ST_ACCESS;
            ram_en_o    <= 1'b1;
            ram_we_o    <= mode;
            ram_wdata_o <= pattern + DATA_W'(ram_addr_o);
          end
        end
        ST_ACCESS: begin
          // Ticks arriving here or in CAPTURE are simply lost, never queued.
          state    <= ST_CAPTURE;
          ram_en_o <= 1'b0;
          ram_we_o <= 1'b0;
        end
        ST_CAPTURE: begin
          if (mode == MODE_READ) begin
            data_o <= ram_rdata_i;
          end
          if (ram_addr_o != LAST_ADDR) begin
            ram_addr_o <= ram_addr_o + 1'b1;
            state      <= ST_WAIT_TICK;
          end else begin
            state  <= ST_DONE;
            done_o <= 1'b1;
`ifndef RAM_STEP_LOOP_EN
            busy_o <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
`ifdef RAM_STEP_LOOP_EN
          ram_addr_o <= '0;
          state      <= ST_WAIT_TICK;
`else
          state      <= ST_IDLE;
`endif
        end
        default: begin
          state    <= ST_IDLE;
          ram_en_o <= 1'b0;
          ram_we_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_step_ctrl.sv
// Scoreboard bench for ram_step_ctrl: expected accesses and done pulses are queued at start,
// a negedge monitor pops and compares them. Build with RAM_STEP_LOOP_EN to test looping.
module tb_ram_step_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
`ifdef RAM_STEP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          busy;
  } done_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_clk = 1'b1;
  logic          slow_hold = 1'b1;
  logic [2:0]    scnt = 3'd0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] pattern = 8'h00;
  logic [DW-1:0] ram_rdata;
  logic          ram_en, ram_we, busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, data;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] model_data = 8'h00;

  acc_t  exp_q [$];
  done_t done_q [$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_rise = -100;
  int last_acc = -100;
  int acc_cnt = 0;

  ram_step_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .slow_clk_i(slow_clk), .start_i(start), .mode_i(mode),
    .pattern_i(pattern), .ram_rdata_i(ram_rdata), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .data_o(data), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Divided clock, period 8 cycles, forced high while slow_hold is set.
  always @(posedge clk) begin
    if (slow_hold) begin
      scnt     <= 3'd0;
      slow_clk <= 1'b1;
    end else begin
      scnt     <= scnt + 3'd1;
      slow_clk <= ~scnt[2];
    end
  end

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Monitor: compares every access and done pulse against the queued expectations.
  initial begin : monitor
    logic  slow_prev;
    acc_t  a;
    done_t d;
    slow_prev = 1'b1;
    forever begin
      @(negedge clk);
      ncyc++;
      if (slow_clk && !slow_prev) last_rise = ncyc;
      slow_prev = slow_clk;
      if (ram_en) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got addr=%0d we=%0d, required no access", ram_addr, ram_we);
        end else begin
          a = exp_q.pop_front();
          if (ram_we !== a.we || ram_addr !== a.addr || (a.we && ram_wdata !== a.wdata)) begin
            errors++;
            $display("FAIL access: got we=%0d addr=%0d wdata=%h, required we=%0d addr=%0d wdata=%h",
                     ram_we, ram_addr, ram_wdata, a.we, a.addr, a.wdata);
          end
          checks++;
          if (last_rise != ncyc - 1) begin
            errors++;
            $display("FAIL tick_align: access at cycle %0d, slow rise at %0d, required rise at %0d",
                     ncyc, last_rise, ncyc - 1);
          end
          if (a.addr != 2'd0) begin
            checks++;
            if (ncyc - last_acc != 8) begin
              errors++;
              $display("FAIL spacing: got %0d cycles, required 8", ncyc - last_acc);
            end
          end
        end
        last_acc = ncyc;
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          d = done_q.pop_front();
          if (data !== d.data || busy !== d.busy) begin
            errors++;
            $display("FAIL done_state: got data=%h busy=%0d, required data=%h busy=%0d",
                     data, busy, d.data, d.busy);
          end
          checks++;
          if (ncyc != last_acc + 2) begin
            errors++;
            $display("FAIL done_timing: got cycle %0d, required %0d", ncyc, last_acc + 2);
          end
        end
      end
    end
  end

  task automatic push_scan(input logic m, input logic [DW-1:0] p);
    acc_t  e;
    done_t d;
    for (int i = 0; i < 4; i++) begin
      e.we    = m;
      e.addr  = i[AW-1:0];
      e.wdata = p + 8'(i);
      exp_q.push_back(e);
      if (m) ref_mem[i] = p + 8'(i);
    end
    if (!m) model_data = ref_mem[3];
    d.data = model_data;
    d.busy = LOOP;
    done_q.push_back(d);
  endtask

  task automatic pulse_start(input logic m, input logic [DW-1:0] p);
    @(posedge clk); #1;
    start = 1'b1; mode = m; pattern = p;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_scan(input logic m, input logic [DW-1:0] p);
    push_scan(m, p);
    pulse_start(m, p);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && (exp_q.size() != 0 || done_q.size() != 0); k++) @(posedge clk);
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d accesses and %0d done pending, required 0", name,
               exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, data, busy, done} !== '0) begin
      errors++;
      $display("FAIL %s: got en=%0d we=%0d addr=%0d wdata=%h data=%h busy=%0d done=%0d, required all 0",
               name, ram_en, ram_we, ram_addr, ram_wdata, data, busy, done);
    end
  endtask

  task automatic check_end(input string name);
    checks++;
    if (ram_addr !== 2'd3 || busy !== LOOP || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL %s: got addr=%0d busy=%0d en=%0d, required addr=3 busy=%0d en=0",
               name, ram_addr, busy, ram_en, LOOP);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int base;
    logic m;
    logic [DW-1:0] p;
    rst = 1'b1;
    slow_hold = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef RAM_STEP_LOOP_EN
    p = 8'($urandom);
    push_scan(1'b1, p);
    push_scan(1'b1, p);
    pulse_start(1'b1, p);
    repeat (3) @(posedge clk);
    #1 slow_hold = 1'b0;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || done_q.size() != 0); k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL loop: pending=%0d busy=%0d, required pending=0 busy=1", exp_q.size(), busy);
    end
    #1 rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    check_zero("loop_reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);
`else
    // Slow clock still held high at reset release: first access only after its next rise.
    start_scan(MODE_FILL_TB(), 8'h10);
    repeat (3) @(posedge clk);
    #1 slow_hold = 1'b0;
    wait_drain("fill_scan");
    check_end("fill_end");

    // Read scan with a stray start pulse mid-scan that must be ignored.
    start_scan(1'b0, 8'h00);
    repeat (12) @(posedge clk);
    #1;
    start = 1'b1; mode = 1'b1; pattern = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("read_scan");
    check_end("read_end");

    for (int it = 0; it < 4; it++) begin
      m = 1'($urandom_range(0, 1));
      p = 8'($urandom);
      start_scan(m, p);
      wait_drain("random_scan");
      check_end("random_end");
    end

    // Abort a read scan two cycles after its second access.
    start_scan(1'b0, 8'h00);
    base = acc_cnt;
    for (int k = 0; k < 100 && acc_cnt < base + 2; k++) @(posedge clk);
    checks++;
    if (acc_cnt < base + 2) begin
      errors++;
      $display("FAIL abort_wait: got %0d accesses, required 2", acc_cnt - base);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    model_data = 8'h00;
    @(posedge clk); #1;
    check_zero("abort_reset");
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_zero("after_abort");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic MODE_FILL_TB();
    return 1'b1;
  endfunction

endmodule

// File: doc/ram_step_ctrl.md
RAM_STEP_CTRL -- requirements
Module: ram_step_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: RAM address width; the scan covers addresses 0 .. 2**ADDR_W-1.
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 clk_i  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 slow_clk_i  in  1  divided clock from the frequency divider, registered in the clk_i domain.
REQ-006 start_i  in  1  one-cycle request to begin a scan.
REQ-007 mode_i  in  1  sampled at start: 0 = read scan, 1 = fill (write) scan.
REQ-008 pattern_i  in  DATA_W  fill base value, sampled at start.
REQ-009 ram_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after ram_en_o.
REQ-010 ram_en_o  out  1  RAM access strobe.
REQ-011 ram_we_o  out  1  write enable, qualified by ram_en_o.
REQ-012 ram_addr_o  out  ADDR_W  current address.
REQ-013 ram_wdata_o  out  DATA_W  write data.
REQ-014 data_o  out  DATA_W  last word read.
REQ-015 busy_o  out  1  scan in progress; done_o  out  1  one-cycle end-of-scan pulse.

Function
REQ-016 The block SHALL derive tick = slow_clk_i AND NOT prev, where prev is slow_clk_i registered once.
REQ-017 The FSM SHALL have states IDLE, WAIT_TICK, ACCESS, CAPTURE and DONE.
REQ-018 In IDLE, start_i=1 SHALL move to WAIT_TICK on the next cycle, with addr=0, busy_o=1, and mode_i and pattern_i latched.
REQ-019 In WAIT_TICK, tick=1 SHALL move to ACCESS; ticks in any other state SHALL be dropped and not queued.
REQ-020 In ACCESS, ram_en_o SHALL be 1 for exactly one cycle, with ram_we_o equal to the latched mode and ram_wdata_o = pattern + addr (mod 2**DATA_W).
REQ-021 In CAPTURE, a read scan SHALL load data_o from ram_rdata_i, and a write scan SHALL leave data_o unchanged.
REQ-022 From CAPTURE, if addr < 2**ADDR_W-1, the FSM SHALL increment addr and return to WAIT_TICK; otherwise it SHALL go to DONE.
REQ-023 DONE SHALL assert done_o for one cycle, deassert busy_o, and return to IDLE; ram_addr_o SHALL hold its last value.
REQ-024 start_i SHALL be ignored whenever busy_o=1.
REQ-025 Access-to-access spacing SHALL equal the slow_clk_i period: exactly one access per rising edge of slow_clk_i.

Reset
REQ-026 rst_i SHALL force state IDLE and set ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, data_o, busy_o and done_o to 0.
REQ-027 rst_i SHALL set prev to 1, so a slow_clk_i that is high at reset release produces no tick (the divider resets its output high).
REQ-028 rst_i asserted mid-scan SHALL abort immediately, with no done_o pulse and no further RAM access.

Configuration
REQ-029 Macro RAM_STEP_LOOP_EN defined: DONE SHALL pulse done_o, reset addr to 0 and return to WAIT_TICK with busy_o kept at 1, looping until rst_i.
REQ-030 Macro RAM_STEP_LOOP_EN undefined: behaviour SHALL be as REQ-023 (single pass).

Structure
REQ-031 Package ram_step_pkg SHALL hold the FSM state typedef and the MODE_READ=0 / MODE_FILL=1 constants.
REQ-032 The tick logic SHALL be sub-module tick_edge_det (ports clk_i, rst_i, level_i, tick_o, with prev reset to 1).

Verification
(Bench: ADDR_W=2, DATA_W=8, slow_clk_i period 8 cycles.)
REQ-033 Fill scan, pattern_i=0x10: 4 writes to addresses 0,1,2,3 with data 0x10,0x11,0x12,0x13, each ram_en_o exactly 8 cycles apart, then one done_o pulse.
REQ-034 Read scan over the filled RAM: data_o = 0x13 after the scan, and done_o fires 1 cycle after the last CAPTURE.
REQ-035 slow_clk_i held high through reset release: no access until the next rising edge of slow_clk_i.
REQ-036 start_i pulsed during the scan: no restart, addr sequence unchanged.
REQ-037 rst_i asserted 2 cycles after the 2nd access: all outputs 0 next cycle, no done_o, no further ram_en_o.
REQ-038 With RAM_STEP_LOOP_EN: after address 3 the scan continues at address 0, with busy_o staying at 1.
